v810_bus_ctrl: RTL and testbench

Parametrised V810 external-bus controller that replaces the ad-hoc glue logic around the CPU.
- Decodes up to NREG memory regions from A/MRQn.
- Asserts one chip enable per region and inserts per-region wait states.
- Generates READYn/SZRQn, including 16-bit bus sizing, and muxes read data onto the CPU data-in bus.
- Sits between the v810 core and ROM/RAM/IO devices; all cycles are qualified by CE.

---
 rtl/v810_bus_pkg.sv | 22 ++
 rtl/v810_bus_ctrl_if.sv | 48 ++++
 rtl/v810_bus_decode.sv | 31 +++
 rtl/v810_bus_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_v810_bus_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/v810_bus_pkg.sv
// Shared types and constants for the V810 external-bus controller.
package v810_bus_pkg;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int WSW = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_t;

  // A region matches when the masked address equals its base.
  function automatic logic region_hit(input logic [AW-1:0] a,
                                      input logic [AW-1:0] base,
                                      input logic [AW-1:0] mask);
    return ((a & mask) == base);
  endfunction

endpackage

// File: rtl/v810_bus_ctrl_if.sv
// CPU-side and memory-side signals of the V810 bus controller.
// Optional error-capture signals exist only when V810_BUS_ERR_EN is defined.
interface v810_bus_ctrl_if
  import v810_bus_pkg::*;
#(
  parameter int NREG = 4
);
  logic               CE;
  logic [AW-1:0]      A;
  logic [3:0]         BEn;
  logic               MRQn;
  logic               RW;
  logic               BCYSTn;
  logic               READYn;
  logic               SZRQn;
  logic [DW-1:0]      D_I;
  logic [NREG-1:0]    MEM_nCE;
  logic               MEM_nWE;
  logic               MEM_nOE;
  logic [NREG*DW-1:0] MEM_DO;
  logic               UNMAPPED;
`ifdef V810_BUS_ERR_EN
  logic [AW-1:0]      ERR_ADDR;
  logic               ERR_VALID;
  logic               ERR_CLR;
`endif

  // CPU and memory devices as seen from outside the controller
  modport master (
    output CE, A, BEn, MRQn, RW, BCYSTn, MEM_DO,
`ifdef V810_BUS_ERR_EN
    output ERR_CLR,
    input  ERR_ADDR, ERR_VALID,
`endif
    input  READYn, SZRQn, D_I, MEM_nCE, MEM_nWE, MEM_nOE, UNMAPPED
  );

  // the controller itself
  modport slave (
    input  CE, A, BEn, MRQn, RW, BCYSTn, MEM_DO,
`ifdef V810_BUS_ERR_EN
    input  ERR_CLR,
    output ERR_ADDR, ERR_VALID,
`endif
    output READYn, SZRQn, D_I, MEM_nCE, MEM_nWE, MEM_nOE, UNMAPPED
  );

endinterface

// File: rtl/v810_bus_decode.sv
// Combinational region decoder: one-hot select of the lowest-index
// region whose masked address matches. Memory space only (MRQn=0).
module v810_bus_decode
  import v810_bus_pkg::*;
#(
  parameter int                  NREG     = 4,
  parameter logic [NREG*AW-1:0]  REG_BASE = {NREG{32'h0}},
  parameter logic [NREG*AW-1:0]  REG_MASK = {NREG{32'h0}}
) (
  input  logic [AW-1:0]   i_a,
  input  logic            i_mrq_n,
  output logic [NREG-1:0] o_sel,
  output logic            o_hit
);

  // scan high to low so the lowest matching index is the one left standing
  always_comb begin
    o_sel = '0;
    o_hit = 1'b0;
    if (!i_mrq_n) begin
      for (int i = NREG - 1; i >= 0; i--) begin
        if (region_hit(i_a, REG_BASE[i*AW +: AW], REG_MASK[i*AW +: AW])) begin
          o_sel    = '0;
          o_sel[i] = 1'b1;
          o_hit    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/v810_bus_ctrl.sv
// V810 external-bus controller: region decode, chip enables, wait states,
// READYn/SZRQn generation and read-data return.
// Define V810_BUS_ERR_EN to add sticky capture of the first unmapped address.
//
// state | meaning
// IDLE  | waiting for BCYSTn with MRQn low
// WAIT  | region selected, counting down its wait states
// ACK   | READYn low for one CE tick
// HOLD  | one idle tick before accepting the next cycle
module v810_bus_ctrl
  import v810_bus_pkg::*;
#(
  parameter int                  NREG     = 4,
  parameter logic [NREG*AW-1:0]  REG_BASE = {NREG{32'h0}},
  parameter logic [NREG*AW-1:0]  REG_MASK = {NREG{32'h0}},
  parameter logic [NREG*WSW-1:0] REG_WS   = {NREG{4'd0}},
  parameter logic [NREG-1:0]     REG_DW16 = {NREG{1'b0}}
) (
  input  logic         CLK,
  input  logic         RES,
  v810_bus_ctrl_if.slave bus
);

  state_t          r_state, w_state_nxt;
  logic [WSW-1:0]  r_cnt, w_cnt_nxt;
  logic [NREG-1:0] r_sel, w_sel_nxt;
  logic            r_rw, w_rw_nxt;
  logic            r_sz, w_sz_nxt;
  logic            r_ready_n, w_ready_n_nxt;
  logic            r_szrq_n, w_szrq_n_nxt;
  logic            r_nwe, w_nwe_nxt;
  logic            r_noe, w_noe_nxt;
  logic            r_unmapped, w_unmapped_nxt;
  logic [DW-1:0]   r_di, w_di_nxt;

  logic [NREG-1:0] w_dsel;
  logic            w_hit;
  logic            w_cyc_start;
  logic [WSW-1:0]  w_ws;
  logic            w_dw16;
  logic [DW-1:0]   w_rdata;
  logic            w_rdw16;

  v810_bus_decode #(
    .NREG     (NREG),
    .REG_BASE (REG_BASE),
    .REG_MASK (REG_MASK)
  ) u_decode (
    .i_a     (bus.A),
    .i_mrq_n (bus.MRQn),
    .o_sel   (w_dsel),
    .o_hit   (w_hit)
  );

  assign w_cyc_start = !bus.BCYSTn && !bus.MRQn;

  // wait-state count and bus width of the region being decoded right now
  always_comb begin
    w_ws   = '0;
    w_dw16 = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (w_dsel[i]) begin
        w_ws   = REG_WS[i*WSW +: WSW];
        w_dw16 = REG_DW16[i];
      end
    end
  end

  // read data and width of the region latched at cycle start
  always_comb begin
    w_rdata = '0;
    w_rdw16 = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      if (r_sel[i]) begin
        w_rdata = bus.MEM_DO[i*DW +: DW];
        w_rdw16 = REG_DW16[i];
      end
    end
  end

  // next-state and next-output logic
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_sel_nxt      = r_sel;
    w_rw_nxt       = r_rw;
    w_sz_nxt       = r_sz;
    w_ready_n_nxt  = r_ready_n;
    w_szrq_n_nxt   = r_szrq_n;
    w_nwe_nxt      = r_nwe;
    w_noe_nxt      = r_noe;
    w_unmapped_nxt = r_unmapped;
    w_di_nxt       = r_di;
    case (r_state)
      IDLE: begin
        if (w_cyc_start) begin
          if (w_hit) begin
            w_sel_nxt   = w_dsel;
            w_cnt_nxt   = w_ws;
            w_rw_nxt    = bus.RW;
            w_noe_nxt   = ~bus.RW;
            w_nwe_nxt   = bus.RW;
            // a 16-bit device cannot serve a lower-word access touching both halves
            w_sz_nxt    = w_dw16 & ~bus.A[1] & (bus.BEn[3:2] != 2'b11)
                          & (bus.BEn[1:0] != 2'b11);
            w_state_nxt = WAIT;
          end else begin
            w_unmapped_nxt = 1'b1;
            w_ready_n_nxt  = 1'b0;
            w_di_nxt       = '0;
            w_state_nxt    = ACK;
          end
        end
      end
      WAIT: begin
        if (r_cnt == '0) begin
          w_ready_n_nxt = 1'b0;
          w_szrq_n_nxt  = ~r_sz;
          if (r_rw) begin
            w_di_nxt = w_rdw16 ? {2{w_rdata[15:0]}} : w_rdata;
          end
          w_state_nxt = ACK;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      ACK: begin
        w_ready_n_nxt  = 1'b1;
        w_szrq_n_nxt   = 1'b1;
        w_sel_nxt      = '0;
        w_nwe_nxt      = 1'b1;
        w_noe_nxt      = 1'b1;
        w_unmapped_nxt = 1'b0;
        w_state_nxt    = HOLD;
      end
      HOLD: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // state and output registers, advancing only on CE ticks
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_sel      <= '0;
      r_rw       <= 1'b1;
      r_sz       <= 1'b0;
      r_ready_n  <= 1'b1;
      r_szrq_n   <= 1'b1;
      r_nwe      <= 1'b1;
      r_noe      <= 1'b1;
      r_unmapped <= 1'b0;
      r_di       <= '0;
    end else if (bus.CE) begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_rw       <= w_rw_nxt;
      r_sz       <= w_sz_nxt;
      r_ready_n  <= w_ready_n_nxt;
      r_szrq_n   <= w_szrq_n_nxt;
      r_nwe      <= w_nwe_nxt;
      r_noe      <= w_noe_nxt;
      r_unmapped <= w_unmapped_nxt;
      r_di       <= w_di_nxt;
    end
  end

  assign bus.READYn   = r_ready_n;
  assign bus.SZRQn    = r_szrq_n;
  assign bus.D_I      = r_di;
  assign bus.MEM_nCE  = ~r_sel;
  assign bus.MEM_nWE  = r_nwe;
  assign bus.MEM_nOE  = r_noe;
  assign bus.UNMAPPED = r_unmapped;

`ifdef V810_BUS_ERR_EN
  logic          w_unmapped_start;
  logic [AW-1:0] r_err_addr;
  logic          r_err_valid;

  assign w_unmapped_start = (r_state == IDLE) && w_cyc_start && !w_hit;

  // sticky capture of the first unmapped address; a capture beats a clear
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_err_addr  <= '0;
      r_err_valid <= 1'b0;
    end else if (bus.CE) begin
      if (w_unmapped_start) begin
        if (!r_err_valid || bus.ERR_CLR) begin
          r_err_addr <= bus.A;
        end
        r_err_valid <= 1'b1;
      end else if (bus.ERR_CLR) begin
        r_err_valid <= 1'b0;
      end
    end
  end

  assign bus.ERR_ADDR  = r_err_addr;
  assign bus.ERR_VALID = r_err_valid;
`endif

endmodule

// File: tb/tb_v810_bus_ctrl.sv
// Directed testbench for v810_bus_ctrl. Region map:
//   0: ROM  FFF00000/FFF00000 WS=2 32-bit
//   1: IO16 00000100/FFFFFF00 WS=0 16-bit
//   2: RAM  00000000/C0000000 WS=1 32-bit
//   3: SLOW FF000000/FF000000 WS=15 32-bit (overlaps region 0)
module tb_v810_bus_ctrl;

  localparam logic [127:0] BASE = {32'hFF000000, 32'h00000000, 32'h00000100, 32'hFFF00000};
  localparam logic [127:0] MASK = {32'hFF000000, 32'hC0000000, 32'hFFFFFF00, 32'hFFF00000};
  localparam logic [15:0]  WS   = {4'd15, 4'd1, 4'd0, 4'd2};
  localparam logic [3:0]   DW16 = 4'b0010;

  logic CLK = 1'b0;
  logic RES;
  int   checks   = 0;
  int   failures = 0;

  v810_bus_ctrl_if #(.NREG(4)) bus ();

  v810_bus_ctrl #(
    .NREG     (4),
    .REG_BASE (BASE),
    .REG_MASK (MASK),
    .REG_WS   (WS),
    .REG_DW16 (DW16)
  ) dut (
    .CLK (CLK),
    .RES (RES),
    .bus (bus)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle_bus();
    bus.BCYSTn = 1'b1;
    bus.MRQn   = 1'b1;
    bus.RW     = 1'b1;
    bus.BEn    = 4'hF;
  endtask

  // present a cycle start for exactly one CE tick
  task automatic start(input logic [31:0] a, input logic rw, input logic [3:0] ben);
    bus.A      = a;
    bus.RW     = rw;
    bus.BEn    = ben;
    bus.MRQn   = 1'b0;
    bus.BCYSTn = 1'b0;
    tick();
    bus.BCYSTn = 1'b1;
  endtask

  task automatic test_reset();
    RES    = 1'b1;
    bus.CE = 1'b1;
    bus.A  = 32'h0;
    bus.MEM_DO = {32'hCAFEBABE, 32'h0BADF00D, 32'hABCD5A5A, 32'h12345678};
`ifdef V810_BUS_ERR_EN
    bus.ERR_CLR = 1'b0;
`endif
    idle_bus();
    tick();
    tick();
    checks++;
    if ({bus.READYn, bus.SZRQn, bus.MEM_nCE, bus.MEM_nWE, bus.MEM_nOE, bus.UNMAPPED} !== 9'b1_1_1111_1_1_0) begin
      failures++;
      $display("FAIL reset_ctrl act=%b%b%b%b%b%b exp=111111110", bus.READYn, bus.SZRQn,
               bus.MEM_nCE, bus.MEM_nWE, bus.MEM_nOE, bus.UNMAPPED);
    end
    checks++;
    if (bus.D_I !== 32'h0) begin failures++; $display("FAIL reset_di act=%h exp=00000000", bus.D_I); end
`ifdef V810_BUS_ERR_EN
    checks++;
    if ({bus.ERR_VALID, bus.ERR_ADDR} !== 33'h0) begin
      failures++; $display("FAIL reset_err act=%b/%h exp=0/00000000", bus.ERR_VALID, bus.ERR_ADDR);
    end
`endif
    RES = 1'b0;
    tick();
  endtask

  task automatic test_rom_read();
    start(32'hFFFFFFF0, 1'b1, 4'h0);
    checks++;
    if ({bus.MEM_nCE, bus.MEM_nOE, bus.MEM_nWE} !== 6'b1110_0_1) begin
      failures++; $display("FAIL rom_strobes act=%b/%b/%b exp=1110/0/1", bus.MEM_nCE, bus.MEM_nOE, bus.MEM_nWE);
    end
    for (int t = 1; t <= 3; t++) begin
      tick();
      checks++;
      if (bus.READYn !== ((t == 3) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL rom_ready_t%0d act=%b exp=%b", t, bus.READYn, (t == 3) ? 1'b0 : 1'b1);
      end
    end
    checks++;
    if (bus.D_I !== 32'h12345678) begin failures++; $display("FAIL rom_di act=%h exp=12345678", bus.D_I); end
    checks++;
    if (bus.SZRQn !== 1'b1) begin failures++; $display("FAIL rom_szrq act=%b exp=1", bus.SZRQn); end
    tick();
    checks++;
    if ({bus.READYn, bus.MEM_nCE, bus.MEM_nOE} !== 6'b1_1111_1) begin
      failures++; $display("FAIL rom_release act=%b/%b/%b exp=1/1111/1", bus.READYn, bus.MEM_nCE, bus.MEM_nOE);
    end
    tick();
    idle_bus();
  endtask

  task automatic test_bus_sizing();
    start(32'h00000100, 1'b1, 4'h0);
    checks++;
    if (bus.MEM_nCE !== 4'b1101) begin failures++; $display("FAIL w16_nce act=%b exp=1101", bus.MEM_nCE); end
    tick();
    checks++;
    if ({bus.READYn, bus.SZRQn} !== 2'b00) begin
      failures++; $display("FAIL w16_lo_ready_szrq act=%b%b exp=00", bus.READYn, bus.SZRQn);
    end
    checks++;
    if (bus.D_I !== 32'h5A5A5A5A) begin failures++; $display("FAIL w16_lo_di act=%h exp=5a5a5a5a", bus.D_I); end
    tick();
    checks++;
    if ({bus.READYn, bus.SZRQn} !== 2'b11) begin
      failures++; $display("FAIL w16_ack_release act=%b%b exp=11", bus.READYn, bus.SZRQn);
    end
    tick();
    bus.MEM_DO[63:32] = 32'hABCD1234;
    start(32'h00000102, 1'b1, 4'h0);
    tick();
    checks++;
    if ({bus.READYn, bus.SZRQn} !== 2'b01) begin
      failures++; $display("FAIL w16_hi_ready_szrq act=%b%b exp=01", bus.READYn, bus.SZRQn);
    end
    checks++;
    if (bus.D_I !== 32'h12341234) begin failures++; $display("FAIL w16_hi_di act=%h exp=12341234", bus.D_I); end
    tick();
    tick();
    start(32'h00000100, 1'b1, 4'b1100);
    tick();
    checks++;
    if ({bus.READYn, bus.SZRQn} !== 2'b01) begin
      failures++; $display("FAIL w16_lowhalf_only act=%b%b exp=01", bus.READYn, bus.SZRQn);
    end
    tick();
    tick();
    idle_bus();
  endtask

  task automatic test_unmapped();
    start(32'h40000000, 1'b1, 4'h0);
    checks++;
    if ({bus.UNMAPPED, bus.READYn, bus.MEM_nCE} !== 6'b1_0_1111) begin
      failures++; $display("FAIL unm_pulse act=%b/%b/%b exp=1/0/1111", bus.UNMAPPED, bus.READYn, bus.MEM_nCE);
    end
    checks++;
    if (bus.D_I !== 32'h0) begin failures++; $display("FAIL unm_di act=%h exp=00000000", bus.D_I); end
`ifdef V810_BUS_ERR_EN
    checks++;
    if ({bus.ERR_VALID, bus.ERR_ADDR} !== {1'b1, 32'h40000000}) begin
      failures++; $display("FAIL err_capture act=%b/%h exp=1/40000000", bus.ERR_VALID, bus.ERR_ADDR);
    end
`endif
    tick();
    checks++;
    if ({bus.UNMAPPED, bus.READYn} !== 2'b01) begin
      failures++; $display("FAIL unm_end act=%b%b exp=01", bus.UNMAPPED, bus.READYn);
    end
    tick();
`ifdef V810_BUS_ERR_EN
    start(32'h70000000, 1'b1, 4'h0);
    checks++;
    if ({bus.ERR_VALID, bus.ERR_ADDR} !== {1'b1, 32'h40000000}) begin
      failures++; $display("FAIL err_sticky act=%b/%h exp=1/40000000", bus.ERR_VALID, bus.ERR_ADDR);
    end
    tick();
    tick();
    idle_bus();
    bus.ERR_CLR = 1'b1;
    tick();
    bus.ERR_CLR = 1'b0;
    checks++;
    if (bus.ERR_VALID !== 1'b0) begin failures++; $display("FAIL err_clear act=%b exp=0", bus.ERR_VALID); end
    bus.ERR_CLR = 1'b1;
    start(32'h60000000, 1'b1, 4'h0);
    bus.ERR_CLR = 1'b0;
    checks++;
    if ({bus.ERR_VALID, bus.ERR_ADDR} !== {1'b1, 32'h60000000}) begin
      failures++; $display("FAIL err_capture_wins act=%b/%h exp=1/60000000", bus.ERR_VALID, bus.ERR_ADDR);
    end
    tick();
    tick();
`endif
    idle_bus();
  endtask

  task automatic test_write();
    start(32'h00001000, 1'b0, 4'h0);
    for (int t = 0; t <= 2; t++) begin
      if (t > 0) tick();
      checks++;
      if ({bus.MEM_nCE, bus.MEM_nWE, bus.MEM_nOE, bus.READYn} !== {4'b1011, 1'b0, 1'b1, (t == 2) ? 1'b0 : 1'b1}) begin
        failures++;
        $display("FAIL wr_t%0d act=%b/%b/%b/%b exp=1011/0/1/%b", t, bus.MEM_nCE, bus.MEM_nWE, bus.MEM_nOE,
                 bus.READYn, (t == 2) ? 1'b0 : 1'b1);
      end
    end
    tick();
    checks++;
    if ({bus.READYn, bus.MEM_nWE, bus.MEM_nCE} !== 6'b1_1_1111) begin
      failures++; $display("FAIL wr_release act=%b/%b/%b exp=1/1/1111", bus.READYn, bus.MEM_nWE, bus.MEM_nCE);
    end
    tick();
    idle_bus();
  endtask

  task automatic test_reset_mid_cycle();
    start(32'hFF000010, 1'b1, 4'h0);
    checks++;
    if (bus.MEM_nCE !== 4'b0111) begin failures++; $display("FAIL slow_nce act=%b exp=0111", bus.MEM_nCE); end
    tick();
    tick();
    #2;
    RES = 1'b1;
    #1;
    checks++;
    if ({bus.READYn, bus.MEM_nCE, bus.MEM_nOE} !== 6'b1_1111_1) begin
      failures++; $display("FAIL rst_abort act=%b/%b/%b exp=1/1111/1", bus.READYn, bus.MEM_nCE, bus.MEM_nOE);
    end
    tick();
    RES = 1'b0;
    idle_bus();
    tick();
    bus.MEM_DO[31:0] = 32'h87654321;
    start(32'hFFF00004, 1'b1, 4'h0);
    tick();
    tick();
    tick();
    checks++;
    if ({bus.READYn, bus.D_I} !== {1'b0, 32'h87654321}) begin
      failures++; $display("FAIL rst_fresh act=%b/%h exp=0/87654321", bus.READYn, bus.D_I);
    end
    tick();
    tick();
    idle_bus();
  endtask

  task automatic test_overlap_freeze();
    start(32'hFFF00010, 1'b1, 4'h0);
    checks++;
    if (bus.MEM_nCE !== 4'b1110) begin failures++; $display("FAIL overlap_nce act=%b exp=1110", bus.MEM_nCE); end
    tick();
    bus.CE = 1'b0;
    for (int t = 0; t < 5; t++) begin
      tick();
      checks++;
      if ({bus.READYn, bus.MEM_nCE} !== 5'b1_1110) begin
        failures++; $display("FAIL freeze_c%0d act=%b/%b exp=1/1110", t, bus.READYn, bus.MEM_nCE);
      end
    end
    bus.CE = 1'b1;
    tick();
    checks++;
    if (bus.READYn !== 1'b1) begin failures++; $display("FAIL thaw_cnt1 act=%b exp=1", bus.READYn); end
    tick();
    checks++;
    if (bus.READYn !== 1'b0) begin failures++; $display("FAIL thaw_done act=%b exp=0", bus.READYn); end
    tick();
    tick();
    idle_bus();
  endtask

  task automatic test_io_space();
    bus.A      = 32'hFFF00000;
    bus.MRQn   = 1'b1;
    bus.BCYSTn = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tick();
      checks++;
      if ({bus.READYn, bus.UNMAPPED, bus.MEM_nCE, bus.MEM_nOE, bus.MEM_nWE} !== 8'b1_0_1111_1_1) begin
        failures++;
        $display("FAIL io_space_t%0d act=%b/%b/%b/%b/%b exp=1/0/1111/1/1", t, bus.READYn, bus.UNMAPPED,
                 bus.MEM_nCE, bus.MEM_nOE, bus.MEM_nWE);
      end
    end
    idle_bus();
    tick();
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_bus_sizing();
    test_unmapped();
    test_write();
    test_reset_mid_cycle();
    test_overlap_freeze();
    test_io_space();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
